// File: rtl/button_cmd_arbiter_pkg.sv
// button_cmd_arbiter_pkg: command codes, button indices, FSM states and grant helpers.
package button_cmd_arbiter_pkg;
   localparam logic [2:0] CMD_NONE = 3'd0, CMD_RIGHT = 3'd1, CMD_LEFT = 3'd2, CMD_DOWN = 3'd3,
                          CMD_UP = 3'd4, CMD_DECISION = 3'd5, CMD_RED_RESET = 3'd6, CMD_BLUE_RESET = 3'd7;
   localparam int BTN_RIGHT = 0, BTN_LEFT = 1, BTN_DOWN = 2, BTN_UP = 3,
                  BTN_DECISION = 4, BTN_RED_RESET = 5, BTN_BLUE_RESET = 6;
   localparam logic [4:0] FLUSH_MASK = 5'b11111;
   typedef enum logic [1:0] {IDLE, WAIT_TICK, OFFER} state_t;
   function automatic logic [2:0] msb_idx(input logic [6:0] v);
      msb_idx = '0;
      for (int i = 0; i < 7; i++) if (v[i]) msb_idx = 3'(i);
   endfunction
endpackage

// File: rtl/button_cmd_arbiter_debounce.sv
// btn_debounce: two-flop synchroniser, counter debouncer and registered press pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_button,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEB_CYCLES);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic flip;
   assign flip = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
   always_ff @(posedge clk)
      if (reset_button) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
         level <= level ^ flip;
         rise  <= flip && !level;
      end
endmodule

// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter: debounced buttons -> pending requests -> one command per tick.
// Define BUTTON_AUTO_REPEAT_EN to auto-repeat held direction buttons.
module button_cmd_arbiter import button_cmd_arbiter_pkg::*; #(
   parameter int N_BTN        = 7,
   parameter int DEB_CYCLES   = 16,
   parameter int REPEAT_TICKS = 4
) (
   input  logic             clk,
   input  logic             reset_button,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             tick,
   output logic             cmd_valid,
   output logic [2:0]       cmd_code,
   input  logic             cmd_ready,
   output logic [N_BTN-1:0] pending,
   output logic             busy,
   output logic [7:0]       drop_count
);
   state_t state;
   logic [N_BTN-1:0] level, rise, req, clr, nxt, drops;
   logic [2:0] idx;
   logic grant;
   logic [8:0] sum;
   for (genvar i = 0; i < N_BTN; i++) begin : g_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk(clk), .reset_button(reset_button), .raw(btn_raw[i]), .level(level[i]), .rise(rise[i]));
   end
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int RW = $clog2(2 * REPEAT_TICKS + 1);
   logic [N_BTN-1:0] rep;
   for (genvar i = 0; i < N_BTN; i++) begin : g_rep
      if (i < 4) begin : g_dir
         logic [RW-1:0] rcnt;
         assign rep[i] = tick && level[i] && rcnt == RW'(2 * REPEAT_TICKS - 1);
         // after the first repeat, restart halfway so later repeats come every REPEAT_TICKS
         always_ff @(posedge clk)
            if (reset_button || !level[i]) rcnt <= '0;
            else if (tick) rcnt <= rep[i] ? RW'(REPEAT_TICKS) : rcnt + 1'b1;
      end else begin : g_none
         assign rep[i] = 1'b0;
      end
   end
   assign req = rise | rep;
`else
   logic unused_rep;
   assign unused_rep = ^level ^ (REPEAT_TICKS == 0);
   assign req = rise;
`endif
   assign grant = state == WAIT_TICK && tick && |pending;
   assign idx   = msb_idx(pending);
   assign clr   = grant ? ((N_BTN'(1) << idx) | (idx >= 3'(BTN_RED_RESET) ? {2'b00, FLUSH_MASK} : '0)) : '0;
   // a press landing on a bit being cleared refills it instead of counting as a drop
   assign nxt   = (pending & ~clr) | req;
   assign drops = req & pending & ~clr;
   assign sum   = {1'b0, drop_count} + 9'($countones(drops));
   assign busy  = state != IDLE;
   always_ff @(posedge clk)
      if (reset_button) begin
         state      <= IDLE;
         cmd_valid  <= 1'b0;
         cmd_code   <= CMD_NONE;
         pending    <= '0;
         drop_count <= '0;
      end else begin
         pending    <= nxt;
         drop_count <= sum[8] ? 8'hFF : sum[7:0];
         case (state)
            IDLE: if (|pending) state <= WAIT_TICK;
            WAIT_TICK: if (grant) begin
               state     <= OFFER;
               cmd_valid <= 1'b1;
               cmd_code  <= idx + 3'd1;
            end
            OFFER: if (cmd_ready) begin
               cmd_valid <= 1'b0;
               cmd_code  <= CMD_NONE;
               state     <= |nxt ? WAIT_TICK : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_button_cmd_arbiter.sv
// tb_button_cmd_arbiter: table-driven directed checks plus reset and saturation sequences.
module tb_button_cmd_arbiter;
   logic clk = 1'b0, reset_button = 1'b1, tick = 1'b0, cmd_ready = 1'b0;
   logic [6:0] btn_raw = '0;
   logic cmd_valid, busy;
   logic [2:0] cmd_code;
   logic [6:0] pending;
   logic [7:0] drop_count;
   int checks = 0, failures = 0;
   typedef struct {
      logic [6:0] btn;
      logic rdy;
      logic tk;
      int n;
      logic v;
      logic [2:0] code;
      logic [6:0] pend;
      logic bsy;
      logic [7:0] drop;
   } vec_t;
   vec_t vt[$];
   button_cmd_arbiter dut (
      .clk(clk), .reset_button(reset_button), .btn_raw(btn_raw), .tick(tick),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
      .pending(pending), .busy(busy), .drop_count(drop_count));
   always #5 clk = ~clk;
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic chk_all(input string nm, input logic v, input logic [2:0] code,
                          input logic [6:0] pend, input logic bsy, input logic [7:0] drop);
      chk({nm, " cmd_valid"}, cmd_valid, v);
      chk({nm, " cmd_code"}, cmd_code, code);
      chk({nm, " pending"}, pending, pend);
      chk({nm, " busy"}, busy, bsy);
      chk({nm, " drop_count"}, drop_count, drop);
   endtask
   initial begin
      // clean press of up
      vt.push_back('{7'h08, 0, 0, 18, 0, 0, 7'h00, 0, 0});
      vt.push_back('{7'h08, 0, 0, 1, 0, 0, 7'h08, 0, 0});
      vt.push_back('{7'h08, 0, 0, 1, 0, 0, 7'h08, 1, 0});
      vt.push_back('{7'h08, 0, 1, 1, 1, 4, 7'h00, 1, 0});
      vt.push_back('{7'h08, 0, 0, 3, 1, 4, 7'h00, 1, 0});
      vt.push_back('{7'h08, 1, 0, 1, 0, 0, 7'h00, 0, 0});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h00, 0, 0});
      // bouncing right never debounces
      for (int i = 0; i < 4; i++) begin
         vt.push_back('{7'h01, 0, 0, 5, 0, 0, 7'h00, 0, 0});
         vt.push_back('{7'h00, 0, 0, 5, 0, 0, 7'h00, 0, 0});
      end
      vt.push_back('{7'h00, 0, 1, 20, 0, 0, 7'h00, 0, 0});
      // up + left priority, ready tied high
      vt.push_back('{7'h0A, 1, 0, 19, 0, 0, 7'h0A, 0, 0});
      vt.push_back('{7'h0A, 1, 0, 1, 0, 0, 7'h0A, 1, 0});
      vt.push_back('{7'h0A, 1, 1, 1, 1, 4, 7'h02, 1, 0});
      vt.push_back('{7'h0A, 1, 0, 1, 0, 0, 7'h02, 1, 0});
      vt.push_back('{7'h0A, 1, 0, 3, 0, 0, 7'h02, 1, 0});
      vt.push_back('{7'h0A, 1, 1, 1, 1, 2, 7'h00, 1, 0});
      vt.push_back('{7'h0A, 1, 0, 1, 0, 0, 7'h00, 0, 0});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h00, 0, 0});
      // red_reset flushes queued moves
      vt.push_back('{7'h0E, 0, 0, 19, 0, 0, 7'h0E, 0, 0});
      vt.push_back('{7'h2E, 0, 0, 19, 0, 0, 7'h2E, 1, 0});
      vt.push_back('{7'h2E, 0, 1, 1, 1, 6, 7'h00, 1, 0});
      vt.push_back('{7'h2E, 1, 0, 1, 0, 0, 7'h00, 0, 0});
      vt.push_back('{7'h00, 0, 1, 20, 0, 0, 7'h00, 0, 0});
      // press on the same edge as its grant keeps pending set, no drop
      vt.push_back('{7'h08, 0, 0, 19, 0, 0, 7'h08, 0, 0});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h08, 1, 0});
      vt.push_back('{7'h08, 0, 0, 18, 0, 0, 7'h08, 1, 0});
      vt.push_back('{7'h08, 0, 1, 1, 1, 4, 7'h08, 1, 0});
      vt.push_back('{7'h08, 1, 0, 1, 0, 0, 7'h08, 1, 0});
      vt.push_back('{7'h08, 0, 1, 1, 1, 4, 7'h00, 1, 0});
      vt.push_back('{7'h08, 1, 0, 1, 0, 0, 7'h00, 0, 0});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h00, 0, 0});
      // decision pressed twice, then stalled across three ticks
      vt.push_back('{7'h10, 0, 0, 19, 0, 0, 7'h10, 0, 0});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h10, 1, 0});
      vt.push_back('{7'h10, 0, 0, 18, 0, 0, 7'h10, 1, 0});
      vt.push_back('{7'h10, 0, 0, 1, 0, 0, 7'h10, 1, 1});
      vt.push_back('{7'h10, 0, 1, 1, 1, 5, 7'h00, 1, 1});
      vt.push_back('{7'h10, 0, 0, 9, 1, 5, 7'h00, 1, 1});
      vt.push_back('{7'h10, 0, 1, 10, 1, 5, 7'h00, 1, 1});
      vt.push_back('{7'h10, 0, 1, 10, 1, 5, 7'h00, 1, 1});
      vt.push_back('{7'h10, 1, 0, 1, 0, 0, 7'h00, 0, 1});
      vt.push_back('{7'h00, 0, 0, 20, 0, 0, 7'h00, 0, 1});
      cyc(2);
      reset_button = 1'b0;
      chk_all("reset", 0, 0, 7'h00, 0, 8'd0);
      foreach (vt[i]) begin
         btn_raw = vt[i].btn;
         cmd_ready = vt[i].rdy;
         tick = vt[i].tk;
         cyc(1);
         tick = 1'b0;
         cyc(vt[i].n - 1);
         chk_all($sformatf("row%0d", i), vt[i].v, vt[i].code, vt[i].pend, vt[i].bsy, vt[i].drop);
      end
      // reset while offering, with the button held through reset release
      btn_raw = 7'h08;
      cmd_ready = 1'b0;
      cyc(20);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      chk("offer valid", cmd_valid, 1);
      chk("offer code", cmd_code, 4);
      reset_button = 1'b1;
      cyc(1);
      reset_button = 1'b0;
      chk_all("reset_in_offer", 0, 0, 7'h00, 0, 8'd0);
      cyc(18);
      chk("held_reset early pending", pending, 0);
      cyc(1);
      chk("held_reset pending", pending, 8);
      btn_raw = 7'h00;
      cyc(20);
      reset_button = 1'b1;
      cyc(2);
      reset_button = 1'b0;
      // drop counter saturation: right stays pending, every later press is dropped
      for (int k = 1; k <= 260; k++) begin
         btn_raw = 7'h01;
         cyc(19);
         btn_raw = 7'h00;
         if (k == 100) chk("drop at 100 presses", drop_count, 99);
         cyc(19);
      end
      chk("drop saturated", drop_count, 255);
      chk("sat pending", pending, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/button_cmd_arbiter.md
Name: button_cmd_arbiter

Overview:
- Sits between the seven raw push-buttons and the board state machine.
- Per button: synchronises, debounces and edge-detects, then latches the press as a pending request.
- Grants at most one request per game tick, by fixed priority, to the single command channel of the state machine (valid/ready).
- A player-reset grant flushes all queued moves.

Parameters:
N_BTN, 7, number of buttons; bit order {blue_reset, red_reset, decision, up, down, left, right}
DEB_CYCLES, 16, consecutive clk cycles a synchronised level must differ from the debounced level before the debounced level flips
REPEAT_TICKS, 4, auto-repeat period in ticks (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
reset_button  input  1  synchronous, active-high reset
btn_raw  input  N_BTN  asynchronous button levels, 1 = pressed
tick  input  1  one-clk strobe marking a state-machine update slot
cmd_valid  output  1  command offered
cmd_code  output  3  command: 0 none, 1 right, 2 left, 3 down, 4 up, 5 decision, 6 red_reset, 7 blue_reset (code = bit index + 1)
cmd_ready  input  1  state machine accepts the command this cycle
pending  output  N_BTN  latched unserved requests
busy  output  1  FSM not in IDLE
drop_count  output  8  presses lost because a request was already pending; saturates at 255

Behaviour:
- Reset, sampled on a clk edge with reset_button=1:
  - clears sync flops, debounced levels, debounce counters, pending, drop_count;
  - drives cmd_valid=0, cmd_code=0, busy=0; FSM goes to IDLE.
- Synchroniser: two flops per bit.
- Debounce, per bit:
  - counter increments while the synchronised level differs from the debounced level;
  - counter clears when the levels are equal;
  - when the counter reaches DEB_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- Edge detection: a 0->1 transition of the debounced level is a press.
- Latency: btn_raw rising at cycle t and held stable gives a debounced flip at t+2+DEB_CYCLES and pending[i]=1 at t+3+DEB_CYCLES.
- Press while pending[i]=1: pending unchanged, drop_count+1 (saturating).
- Same-cycle clear and new press on bit i: the press wins and pending[i] stays 1, with no drop counted.
- FSM:
  - IDLE: pending != 0 -> WAIT_TICK.
  - WAIT_TICK: on tick=1, grant the highest set index of pending:
    - cmd_code <= index+1;
    - clear pending[index];
    - if index is 5 or 6, also clear pending[4:0] (drops are not counted for flushed bits);
    - -> OFFER.
  - OFFER: cmd_valid=1; cmd_code held stable until cmd_valid&&cmd_ready. Handshake cycle: next cycle cmd_valid=0 and cmd_code=0; go to WAIT_TICK if pending != 0, else IDLE.
  - A tick arriving during OFFER is ignored; ticks are not queued.
- Throughput: at most one command per tick. A grant needs a tick seen in WAIT_TICK, so back-to-back commands are separated by at least one tick.
- Button held across reset release: it is debounced afresh and produces a press DEB_CYCLES+3 cycles after reset deasserts.
- Reset in OFFER: the command is abandoned; cmd_valid drops on the reset edge.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- With the macro, bits 3:0 (up/down/left/right):
  - while held debounced-high, re-raise pending after 2*REPEAT_TICKS ticks;
  - then re-raise every REPEAT_TICKS ticks;
  - the per-bit tick counter clears on release or reset;
  - repeats hitting an already-set pending bit are counted in drop_count.
- Without the macro: edge-only requests; the repeat counters and REPEAT_TICKS are unused.

Decomposition:
- Shared package:
  - command code localparams CMD_NONE..CMD_BLUE_RESET;
  - button index constants BTN_RIGHT=0..BTN_BLUE_RESET=6;
  - FSM state encoding IDLE/WAIT_TICK/OFFER;
  - the flush mask 5'b11111.
- Sub-module btn_debounce: 2-flop sync, debounce counter, rising-edge pulse output. Instantiated N_BTN times via generate; the arbiter holds pending, priority, FSM and drop_count.

Test Plan (DEB_CYCLES=16, tick every 10 clks unless stated):
- Reset: reset_button=1 for 2 clks with buttons idle -> cmd_valid=0, cmd_code=0, pending=0, busy=0, drop_count=0.
- Clean press: up held from cycle 0 -> pending=7'b0001000 at cycle 19, busy=1. First tick after that gives cmd_valid=1, cmd_code=4. With cmd_ready=1 one clk later, cmd_valid=0 next clk, pending=0, back to IDLE.
- Bounce: right toggling every 5 clks for 40 clks then low -> debounced level never flips, pending stays 0, no command.
- Priority: up and left pending together, cmd_ready tied 1 -> first tick grants code 4, next tick grants code 2, then IDLE.
- Flush: up, left, down pending, then red_reset pressed before the tick -> grant code 6, pending=0 after the grant, no further commands, drop_count unchanged.
- Stall/drop: decision pressed, released and pressed again before any tick, cmd_ready=0 for 3 ticks -> drop_count=1; cmd_valid=1 with code 5 stable across all 3 ticks; accepted on the cycle cmd_ready=1.
